// File: rtl/inst_fetch_queue.sv
// RV32I fetch stage: PC generation, in-order instruction memory reads,
// DEPTH-entry instruction queue, redirect flush. Option: FETCH_ALIGN_CHECK_EN.
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        iClk,
  input  logic        iRst,
  output logic        oMemReq,
  output logic [31:0] oMemAddr,
  input  logic        iMemGnt,
  input  logic        iMemRvalid,
  input  logic [31:0] iMemRdata,
  output logic        oInstValid,
  output logic [31:0] oInst,
  output logic [31:0] oInstPc,
  input  logic        iInstReady,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPc,
  output logic        oMisalign
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [CW-1:0] count;
  logic [CW-1:0] countNext;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstandingNext;
  logic [CW-1:0] drop;
  logic [CW-1:0] dropNext;
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] wrPtrNext;
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] rdPtrNext;
  logic [31:0]   fetchPc;
  logic [31:0]   fetchPcNext;
  logic [31:0]   rspPc;
  logic [31:0]   rspPcNext;
  logic [31:0]   instQ [DEPTH];
  logic [31:0]   pcQ   [DEPTH];
  logic [31:0]   redirPc;
  logic [CW:0]   inUse;
  logic          halted;
  logic          reqFire;
  logic          push;
  logic          pop;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign;
  logic misalignNext;

  assign redirPc = iRedirectPc;
  assign halted  = misalign;
  assign oMisalign = misalign;

  // Sticky flag: any redirect to a non-word address stops fetch
  always_comb begin
    misalignNext = misalign;
    if (iRedirect && (iRedirectPc[1:0] != 2'b00)) begin
      misalignNext = 1'b1;
    end
  end

  // Misalign flag register
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      misalign <= 1'b0;
    end else begin
      misalign <= misalignNext;
    end
  end
`else
  logic unusedPcLow;

  assign unusedPcLow = ^iRedirectPc[1:0];
  assign redirPc   = {iRedirectPc[31:2], 2'b00};
  assign halted    = 1'b0;
  assign oMisalign = 1'b0;
`endif

  // Request gating: reads in queue plus reads in flight never exceed DEPTH
  always_comb begin
    inUse   = {1'b0, count} + {1'b0, outstanding};
    oMemReq = iRst && (inUse < DEPTH_W)
           && !iRedirect && !halted;
    oMemAddr = fetchPc;
    reqFire  = oMemReq && iMemGnt;
  end

  // Head of queue drives decode; zeros when empty
  always_comb begin
    oInstValid = (count != '0);
    oInst      = '0;
    oInstPc    = '0;
    if (oInstValid) begin
      oInst   = instQ[rdPtr];
      oInstPc = pcQ[rdPtr];
    end
  end

  // A redirect overrides both push and pop for the cycle
  always_comb begin
    push = iMemRvalid && (drop == '0) && !iRedirect;
    pop  = oInstValid && iInstReady && !iRedirect;
  end

  // Queue occupancy and pointer update
  always_comb begin
    countNext = count;
    wrPtrNext = wrPtr;
    rdPtrNext = rdPtr;
    unique case (1'b1)
      iRedirect: begin
        countNext = '0;
        wrPtrNext = '0;
        rdPtrNext = '0;
      end
      (push && !pop): begin
        countNext = count + 1'b1;
        wrPtrNext = wrPtr + 1'b1;
      end
      (pop && !push): begin
        countNext = count - 1'b1;
        rdPtrNext = rdPtr + 1'b1;
      end
      (push && pop): begin
        wrPtrNext = wrPtr + 1'b1;
        rdPtrNext = rdPtr + 1'b1;
      end
      default: begin
        countNext = count;
      end
    endcase
  end

  // In-flight tracking; on redirect every read still pending is stale
  always_comb begin
    outstandingNext = outstanding + CW'(reqFire) - CW'(iMemRvalid);
    dropNext = drop;
    if (iRedirect) begin
      dropNext = outstanding - CW'(iMemRvalid);
    end else if (iMemRvalid && (drop != '0)) begin
      dropNext = drop - 1'b1;
    end
  end

  // Fetch and response PC sequencing
  always_comb begin
    fetchPcNext = fetchPc;
    rspPcNext   = rspPc;
    if (iRedirect) begin
      fetchPcNext = redirPc;
      rspPcNext   = redirPc;
    end else begin
      if (reqFire) begin
        fetchPcNext = fetchPc + 32'd4;
      end
      if (push) begin
        rspPcNext = rspPc + 32'd4;
      end
    end
  end

  // Control state registers
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      wrPtr       <= '0;
      rdPtr       <= '0;
      fetchPc     <= RESET_PC;
      rspPc       <= RESET_PC;
    end else begin
      count       <= countNext;
      outstanding <= outstandingNext;
      drop        <= dropNext;
      wrPtr       <= wrPtrNext;
      rdPtr       <= rdPtrNext;
      fetchPc     <= fetchPcNext;
      rspPc       <= rspPcNext;
    end
  end

  // Queue storage: instruction word and its PC
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instQ[i] <= '0;
        pcQ[i]   <= '0;
      end
    end else if (push) begin
      instQ[wrPtr] <= iMemRdata;
      pcQ[wrPtr]   <= rspPc;
    end
  end

  // Memory must never answer a read that was not requested
  rspWithoutReq: assert property (
    @(posedge iClk) disable iff (!iRst)
    !(iMemRvalid && (outstanding == '0))
  );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: vector table plus
// hand sequences for back-pressure, redirect corners and alignment.
module tb_inst_fetch_queue;

  logic        iClk;
  logic        iRst;
  logic        oMemReq;
  logic [31:0] oMemAddr;
  logic        iMemGnt;
  logic        iMemRvalid;
  logic [31:0] iMemRdata;
  logic        oInstValid;
  logic [31:0] oInst;
  logic [31:0] oInstPc;
  logic        iInstReady;
  logic        iRedirect;
  logic [31:0] iRedirectPc;
  logic        oMisalign;

  inst_fetch_queue #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .oMemReq     (oMemReq),
    .oMemAddr    (oMemAddr),
    .iMemGnt     (iMemGnt),
    .iMemRvalid  (iMemRvalid),
    .iMemRdata   (iMemRdata),
    .oInstValid  (oInstValid),
    .oInst       (oInst),
    .oInstPc     (oInstPc),
    .iInstReady  (iInstReady),
    .iRedirect   (iRedirect),
    .iRedirectPc (iRedirectPc),
    .oMisalign   (oMisalign)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  typedef struct {
    bit          rst;
    int          lat;
    bit          ready;
    bit          redir;
    logic [31:0] rpc;
    bit          expReq;
    logic [31:0] expAddr;
    bit          expValid;
    logic [31:0] expPc;
  } vec_t;

  rsp_t respQ[$];
  vec_t vecs[$];
  int   cyc;
  int   lat;
  int   nChecks;
  int   nFail;

  localparam logic [31:0] SALT = 32'hA5A5_0000;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit rst, input int l,
                              input bit rdy, input bit rd,
                              input logic [31:0] rpc,
                              input bit eReq, input logic [31:0] eAddr,
                              input bit eV, input logic [31:0] ePc);
    vec_t v;
    v.rst = rst;
    v.lat = l;
    v.ready = rdy;
    v.redir = rd;
    v.rpc = rpc;
    v.expReq = eReq;
    v.expAddr = eAddr;
    v.expValid = eV;
    v.expPc = ePc;
    return v;
  endfunction

  task automatic doReset(input int l);
    iRst = 1'b0;
    iInstReady = 1'b0;
    iRedirect = 1'b0;
    iRedirectPc = '0;
    iMemRvalid = 1'b0;
    iMemRdata = '0;
    #1;
    chk("rst_req", {31'b0, oMemReq}, 32'd0);
    chk("rst_valid", {31'b0, oInstValid}, 32'd0);
    chk("rst_inst", oInst, 32'd0);
    chk("rst_pc", oInstPc, 32'd0);
    chk("rst_misalign", {31'b0, oMisalign}, 32'd0);
    respQ.delete();
    cyc = 0;
    lat = l;
    @(posedge iClk);
    @(negedge iClk);
    iRst = 1'b1;
  endtask

  task automatic drive(input bit rdy, input bit rd,
                       input logic [31:0] rpc);
    iInstReady = rdy;
    iRedirect = rd;
    iRedirectPc = rpc;
    if (respQ.size() > 0 && respQ[0].due == cyc) begin
      iMemRvalid = 1'b1;
      iMemRdata = respQ[0].addr ^ SALT;
    end else begin
      iMemRvalid = 1'b0;
      iMemRdata = '0;
    end
    #1;
  endtask

  task automatic adv();
    logic        f;
    logic [31:0] a;
    logic        rv;
    f = oMemReq & iMemGnt;
    a = oMemAddr;
    rv = iMemRvalid;
    @(posedge iClk);
    if (rv) void'(respQ.pop_front());
    if (f) respQ.push_back('{addr: a, due: cyc + lat});
    cyc++;
    @(negedge iClk);
  endtask

  task automatic chkHead(input string nm, input bit eV,
                         input logic [31:0] ePc);
    chk({nm, "_valid"}, {31'b0, oInstValid}, {31'b0, eV});
    chk({nm, "_pc"}, oInstPc, eV ? ePc : 32'd0);
    chk({nm, "_inst"}, oInst, eV ? (ePc ^ SALT) : 32'd0);
  endtask

  initial begin
    nChecks = 0;
    nFail = 0;
    cyc = 0;
    lat = 1;
    iRst = 1'b0;
    iMemGnt = 1'b1;
    iMemRvalid = 1'b0;
    iMemRdata = '0;
    iInstReady = 1'b0;
    iRedirect = 1'b0;
    iRedirectPc = '0;

    // streaming, zero-wait memory
    vecs.push_back(mk(1, 1, 1, 0, 0, 1, 32'h0,  0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 32'h4,  0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 32'h8,  1, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 32'hC,  1, 32'h4));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 32'h10, 1, 32'h8));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 32'h14, 1, 32'hC));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 32'h18, 1, 32'h10));
    // latency 3, redirect with two reads in flight
    vecs.push_back(mk(1, 3, 1, 0, 0, 1, 32'h0, 0, 0));
    vecs.push_back(mk(0, 3, 1, 0, 0, 1, 32'h4, 0, 0));
    vecs.push_back(mk(0, 3, 1, 1, 32'h100, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3, 1, 0, 0, 1, 32'h100, 0, 0));
    vecs.push_back(mk(0, 3, 1, 0, 0, 1, 32'h104, 0, 0));
    vecs.push_back(mk(0, 3, 1, 0, 0, 1, 32'h108, 0, 0));
    vecs.push_back(mk(0, 3, 1, 0, 0, 1, 32'h10C, 0, 0));
    vecs.push_back(mk(0, 3, 1, 0, 0, 0, 0, 1, 32'h100));
    vecs.push_back(mk(0, 3, 1, 0, 0, 1, 32'h110, 1, 32'h104));
    vecs.push_back(mk(0, 3, 1, 0, 0, 1, 32'h114, 1, 32'h108));
    // address wrap
    vecs.push_back(mk(1, 1, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 32'h0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 32'h4, 1, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 32'h8, 1, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 32'hC, 1, 32'h4));

    foreach (vecs[i]) begin
      if (vecs[i].rst) doReset(vecs[i].lat);
      drive(vecs[i].ready, vecs[i].redir, vecs[i].rpc);
      chk($sformatf("v%0d_req", i), {31'b0, oMemReq},
          {31'b0, vecs[i].expReq});
      if (vecs[i].expReq) begin
        chk($sformatf("v%0d_addr", i), oMemAddr, vecs[i].expAddr);
      end
      chkHead($sformatf("v%0d", i), vecs[i].expValid, vecs[i].expPc);
      adv();
    end

    // back-pressure: fill to DEPTH, then drain in order
    doReset(1);
    for (int c = 0; c < 10; c++) begin
      drive(0, 0, 0);
      if (c >= 2) chkHead($sformatf("bp%0d", c), 1, 32'h0);
      adv();
    end
    drive(0, 0, 0);
    chk("bp_req", {31'b0, oMemReq}, 32'd0);
    chk("bp_count", 32'(dut.count), 32'd4);
    chk("bp_outst", 32'(dut.outstanding), 32'd0);
    drive(1, 0, 0);
    chk("bp_rel_req", {31'b0, oMemReq}, 32'd0);
    chkHead("bp_rel0", 1, 32'h0);
    adv();
    for (int k = 1; k <= 4; k++) begin
      drive(1, 0, 0);
      chkHead($sformatf("bp_rel%0d", k), 1, 32'(4 * k));
      adv();
    end

    // redirect coinciding with a response and a pop
    doReset(2);
    for (int c = 0; c < 5; c++) begin
      drive(1, 0, 0);
      adv();
    end
    drive(1, 1, 32'h200);
    chkHead("rc_pre", 1, 32'h8);
    chk("rc_rvalid", {31'b0, iMemRvalid}, 32'd1);
    chk("rc_req", {31'b0, oMemReq}, 32'd0);
    adv();
    drive(1, 0, 0);
    chkHead("rc_c6", 0, 0);
    chk("rc_drop", 32'(dut.drop), 32'd1);
    chk("rc_addr", oMemAddr, 32'h200);
    adv();
    drive(1, 0, 0);
    chkHead("rc_c7", 0, 0);
    adv();
    drive(1, 0, 0);
    chkHead("rc_c8", 0, 0);
    adv();
    drive(1, 0, 0);
    chkHead("rc_c9", 1, 32'h200);
    adv();

    // misaligned redirect
    doReset(1);
    drive(1, 1, 32'h102);
    adv();
    drive(1, 0, 0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("ma_flag", {31'b0, oMisalign}, 32'd1);
    chk("ma_req", {31'b0, oMemReq}, 32'd0);
    adv();
    for (int c = 2; c < 5; c++) begin
      drive(1, 0, 0);
      chk($sformatf("ma_req%0d", c), {31'b0, oMemReq}, 32'd0);
      chkHead($sformatf("ma%0d", c), 0, 0);
      adv();
    end
`else
    chk("ma_flag", {31'b0, oMisalign}, 32'd0);
    chk("ma_req", {31'b0, oMemReq}, 32'd1);
    chk("ma_addr", oMemAddr, 32'h100);
    adv();
    drive(1, 0, 0);
    adv();
    drive(1, 0, 0);
    chkHead("ma_c3", 1, 32'h100);
    adv();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
